// File: rtl/mfp_ahb_arbiter.sv
// Two-master AHB-lite arbiter: M0 (MIPSfpga core) and M1 (DMA/sprite engine) share one slave bus.
// Round-robin handover on owner IDLE, beat-count fairness grant withdrawal, HMASTLOCK honoured.
module mfp_ahb_arbiter #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic        M0_HMASTLOCK,
  input  logic [31:0] M0_HWDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic        M1_HMASTLOCK,
  input  logic [31:0] M1_HWDATA,
  output logic        M0_HREADY,
  output logic        M1_HREADY,
  output logic        M0_HGRANT,
  output logic        M1_HGRANT,
  input  logic [31:0] HRDATA_S,
  input  logic        HREADY_S,
  input  logic        HRESP_S,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  output logic        HMASTER
);

  typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

  owner_t           owner, dp_owner;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       own_trans;
  logic             own_lock, req_other, do_switch, beat, hold_expired;

  always_comb begin
    own_trans    = (owner == OWN_M1) ? M1_HTRANS    : M0_HTRANS;
    own_lock     = (owner == OWN_M1) ? M1_HMASTLOCK : M0_HMASTLOCK;
    req_other    = (owner == OWN_M1) ? M0_HTRANS[1] : M1_HTRANS[1];
    beat         = HREADY_S && own_trans[1];
    do_switch    = HREADY_S && (own_trans == 2'b00) && !own_lock && req_other;
    hold_expired = (cnt == CNT_MAX) && !own_lock;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner    <= OWN_M0;
      dp_owner <= OWN_M0;
      cnt      <= '0;
    end else begin
      if (HREADY_S)
        dp_owner <= owner;
      if (do_switch)
        owner <= (owner == OWN_M1) ? OWN_M0 : OWN_M1;
      if (do_switch || !req_other)
        cnt <= '0;
      else if (beat && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    HADDR     = (owner == OWN_M1) ? M1_HADDR  : M0_HADDR;
    HTRANS    = own_trans;
    HWRITE    = (owner == OWN_M1) ? M1_HWRITE : M0_HWRITE;
    HSIZE     = (owner == OWN_M1) ? M1_HSIZE  : M0_HSIZE;
    HBURST    = (owner == OWN_M1) ? M1_HBURST : M0_HBURST;
    HPROT     = (owner == OWN_M1) ? M1_HPROT  : M0_HPROT;
    HMASTLOCK = own_lock;
    HWDATA    = (dp_owner == OWN_M1) ? M1_HWDATA : M0_HWDATA;
    HRDATA    = HRDATA_S;
    HRESP     = HRESP_S;
    HMASTER   = (owner == OWN_M1);
  end

  // Readies are forced high in reset so a stalled master is released immediately.
  always_comb begin
    M0_HREADY = 1'b1;
    M1_HREADY = 1'b1;
    M0_HGRANT = 1'b0;
    M1_HGRANT = 1'b0;
    if (HRESETn) begin
      if (owner == OWN_M0) begin
        M0_HREADY = HREADY_S;
        M1_HREADY = !M1_HTRANS[1];
        M0_HGRANT = !hold_expired;
      end else begin
        M1_HREADY = HREADY_S;
        M0_HREADY = !M0_HTRANS[1];
        M1_HGRANT = !hold_expired;
      end
    end else begin
      M0_HGRANT = 1'b1;
    end
  end

endmodule
